// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. It cascades the per-stage stall requests,
// tracks outstanding inst/data bus transactions and sequences exception flushes.
module pipeline_ctrl #(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_stall,
    input  logic        id_req_stall,
    input  logic        exe_req_stall,
    input  logic        mem_req_stall,
    input  logic        inst_issue,
    input  logic        inst_done,
    input  logic        data_issue,
    input  logic        data_done,
    input  logic        exception_in,
    input  logic [31:0] exception_pc_in,
    output logic [3:0]  stall,
    output logic        exception,
    output logic        flush_pc_valid,
    output logic [31:0] flush_pc,
    output logic        inst_req_ok,
    output logic        data_req_ok,
    output logic        cnt_err
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic             cnt_err_q, cnt_err_d;
    logic             inst_err, data_err;
    logic             drained;
    logic [3:0]       stall_raw;

    // Returns {error, next_count}; a saturating step flags the error instead of wrapping.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                 input logic issue,
                                                 input logic done);
        logic [CNT_W-1:0] nxt;
        logic             err;
        nxt = cnt;
        err = 1'b0;
        if (issue && !done) begin
            if (cnt >= CNT_MAX) err = 1'b1;
            else                nxt = cnt + CNT_ONE;
        end else if (done && !issue) begin
            if (cnt == CNT_ZERO) err = 1'b1;
            else                 nxt = cnt - CNT_ONE;
        end
        return {err, nxt};
    endfunction

    always_comb begin
        {inst_err, inst_cnt_d} = cnt_step(inst_cnt_q, inst_issue, inst_done);
        {data_err, data_cnt_d} = cnt_step(data_cnt_q, data_issue, data_done);
        cnt_err_d = cnt_err_q | inst_err | data_err;
    end

    assign drained = (inst_cnt_d == CNT_ZERO) && (data_cnt_d == CNT_ZERO);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_RUN: begin
                if (exception_in) begin
                    pc_d    = exception_pc_in;
                    state_d = drained ? ST_FLUSH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
            pc_q       <= '0;
            cnt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_cnt_q <= inst_cnt_d;
            data_cnt_q <= data_cnt_d;
            pc_q       <= pc_d;
            cnt_err_q  <= cnt_err_d;
        end
    end

    always_comb begin
        stall_raw = 4'b0000;
        case (state_q)
            ST_RUN: begin
                stall_raw[3] = mem_req_stall;
                stall_raw[2] = exe_req_stall | stall_raw[3];
                stall_raw[1] = id_req_stall  | stall_raw[2];
                stall_raw[0] = if_req_stall  | stall_raw[1];
            end
            ST_DRAIN: stall_raw = 4'b1111;
            default:  stall_raw = 4'b0000;
        endcase
    end

    // Combinational outputs are gated so they read zero while reset is asserted.
    assign stall          = stall_raw & {4{rst}};
    assign inst_req_ok    = rst && (state_q == ST_RUN) && (inst_cnt_q < CNT_MAX);
    assign data_req_ok    = rst && (state_q == ST_RUN) && (data_cnt_q < CNT_MAX);
    assign exception      = (state_q == ST_FLUSH);
    assign flush_pc_valid = (state_q == ST_FLUSH);
    assign flush_pc       = (state_q == ST_FLUSH) ? pc_q : 32'h0;
    assign cnt_err        = cnt_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: stall cascade, flush sequencing,
// outstanding counters and asynchronous reset.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req_stall, id_req_stall, exe_req_stall, mem_req_stall;
    logic        inst_issue, inst_done, data_issue, data_done;
    logic        exception_in;
    logic [31:0] exception_pc_in;
    logic [3:0]  stall;
    logic        exception, flush_pc_valid;
    logic [31:0] flush_pc;
    logic        inst_req_ok, data_req_ok, cnt_err;

    int errors = 0;
    int checks = 0;

    pipeline_ctrl #(
        .MAX_OUT (2),
        .CNT_W   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req_stall    (if_req_stall),
        .id_req_stall    (id_req_stall),
        .exe_req_stall   (exe_req_stall),
        .mem_req_stall   (mem_req_stall),
        .inst_issue      (inst_issue),
        .inst_done       (inst_done),
        .data_issue      (data_issue),
        .data_done       (data_done),
        .exception_in    (exception_in),
        .exception_pc_in (exception_pc_in),
        .stall           (stall),
        .exception       (exception),
        .flush_pc_valid  (flush_pc_valid),
        .flush_pc        (flush_pc),
        .inst_req_ok     (inst_req_ok),
        .data_req_ok     (data_req_ok),
        .cnt_err         (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_stall    = 1'b0;
        id_req_stall    = 1'b0;
        exe_req_stall   = 1'b0;
        mem_req_stall   = 1'b0;
        inst_issue      = 1'b0;
        inst_done       = 1'b0;
        data_issue      = 1'b0;
        data_done       = 1'b0;
        exception_in    = 1'b0;
        exception_pc_in = 32'h0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        if_req_stall = 1'b1;
        rst = 1'b0;
        #2;
        checks++;
        if (stall !== 4'b0000) begin
            errors++; $display("FAIL reset_stall: got %b want 0000", stall);
        end
        checks++;
        if ({inst_req_ok, data_req_ok} !== 2'b00) begin
            errors++; $display("FAIL reset_req_ok: got %b want 00", {inst_req_ok, data_req_ok});
        end
        checks++;
        if ({exception, flush_pc_valid, cnt_err} !== 3'b000 || flush_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got exc/fpv/err=%b pc=%h want 000 0",
                     {exception, flush_pc_valid, cnt_err}, flush_pc);
        end
        #10 rst = 1'b1;
        if_req_stall = 1'b0;
        tick();
        checks++;
        if ({inst_req_ok, data_req_ok} !== 2'b11) begin
            errors++; $display("FAIL post_reset_req_ok: got %b want 11", {inst_req_ok, data_req_ok});
        end
    endtask

    task automatic test_stall_cascade();
        logic [3:0] vec [5];  // {if, id, exe, mem}
        logic [3:0] exp [5];
        vec[0] = 4'b1000; exp[0] = 4'b0001;
        vec[1] = 4'b0010; exp[1] = 4'b0111;
        vec[2] = 4'b0001; exp[2] = 4'b1111;
        vec[3] = 4'b0100; exp[3] = 4'b0011;
        vec[4] = 4'b0000; exp[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            {if_req_stall, id_req_stall, exe_req_stall, mem_req_stall} = vec[i];
            #1;
            checks++;
            if (stall !== exp[i]) begin
                errors++; $display("FAIL stall_cascade[%0d]: got %b want %b", i, stall, exp[i]);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush_idle();
        exception_in    = 1'b1;
        exception_pc_in = 32'hBFC0_0380;
        #1;
        checks++;
        if (exception !== 1'b0) begin
            errors++; $display("FAIL idle_same_cycle: got exception=%b want 0", exception);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if ({exception, flush_pc_valid} !== 2'b11 || flush_pc !== 32'hBFC0_0380) begin
            errors++;
            $display("FAIL idle_flush: got exc/fpv=%b pc=%h want 11 bfc00380",
                     {exception, flush_pc_valid}, flush_pc);
        end
        checks++;
        if (stall !== 4'b0000 || inst_req_ok !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_stall: got stall=%b ok=%b want 0000 0", stall, inst_req_ok);
        end
        tick();
        checks++;
        if ({exception, flush_pc_valid} !== 2'b00 || flush_pc !== 32'h0 || stall !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_flush: got exc/fpv=%b pc=%h stall=%b want 00 0 0000",
                     {exception, flush_pc_valid}, flush_pc, stall);
        end
        checks++;
        if ({inst_req_ok, data_req_ok} !== 2'b11) begin
            errors++; $display("FAIL idle_after_ok: got %b want 11", {inst_req_ok, data_req_ok});
        end
    endtask

    task automatic test_drain();
        inst_issue = 1'b1;
        data_issue = 1'b1;
        tick();
        clear_inputs();
        exception_in    = 1'b1;
        exception_pc_in = 32'h1234_5678;
        tick();
        clear_inputs();
        checks++;
        if (stall !== 4'b1111 || {inst_req_ok, data_req_ok} !== 2'b00) begin
            errors++;
            $display("FAIL drain_state: got stall=%b ok=%b want 1111 00",
                     stall, {inst_req_ok, data_req_ok});
        end
        for (int cyc = 1; cyc <= 7; cyc++) begin
            inst_done = (cyc == 3);
            data_done = (cyc == 5);
            #1;
            checks++;
            if (exception !== (cyc == 6)) begin
                errors++;
                $display("FAIL drain_pulse[t+%0d]: got exception=%b want %b",
                         cyc, exception, (cyc == 6));
            end
            if (cyc == 6) begin
                checks++;
                if (flush_pc !== 32'h1234_5678) begin
                    errors++; $display("FAIL drain_pc: got %h want 12345678", flush_pc);
                end
            end
            tick();
        end
        clear_inputs();
        checks++;
        if ({inst_req_ok, data_req_ok} !== 2'b11 || cnt_err !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got ok=%b err=%b want 11 0",
                     {inst_req_ok, data_req_ok}, cnt_err);
        end
    endtask

    task automatic test_second_exception();
        inst_issue = 1'b1;
        tick();
        clear_inputs();
        exception_in    = 1'b1;
        exception_pc_in = 32'hAAAA_0000;
        tick();
        exception_pc_in = 32'h8000_0180;
        tick();
        clear_inputs();
        inst_done = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (exception !== 1'b1 || flush_pc !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL second_exc_pc: got exc=%b pc=%h want 1 aaaa0000", exception, flush_pc);
        end
        tick();
        checks++;
        if (exception !== 1'b0) begin
            errors++; $display("FAIL second_exc_extra: got exception=%b want 0", exception);
        end
    endtask

    task automatic test_counters();
        inst_issue = 1'b1;
        tick();
        checks++;
        if (inst_req_ok !== 1'b1) begin
            errors++; $display("FAIL cnt_one_ok: got %b want 1", inst_req_ok);
        end
        tick();
        checks++;
        if (inst_req_ok !== 1'b0 || cnt_err !== 1'b0) begin
            errors++; $display("FAIL cnt_full: got ok=%b err=%b want 0 0", inst_req_ok, cnt_err);
        end
        tick();
        inst_issue = 1'b0;
        checks++;
        if (cnt_err !== 1'b1 || inst_req_ok !== 1'b0) begin
            errors++; $display("FAIL cnt_overflow: got err=%b ok=%b want 1 0", cnt_err, inst_req_ok);
        end
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        checks++;
        if (inst_req_ok !== 1'b1) begin
            errors++; $display("FAIL cnt_held_at_max: got ok=%b want 1", inst_req_ok);
        end
        inst_issue = 1'b1;
        inst_done  = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (inst_req_ok !== 1'b1) begin
            errors++; $display("FAIL cnt_issue_done: got ok=%b want 1", inst_req_ok);
        end
        do_reset();
        checks++;
        if (cnt_err !== 1'b0) begin
            errors++; $display("FAIL cnt_err_reset: got %b want 0", cnt_err);
        end
        data_done = 1'b1;
        tick();
        data_done = 1'b0;
        checks++;
        if (cnt_err !== 1'b1 || data_req_ok !== 1'b1) begin
            errors++; $display("FAIL cnt_underflow: got err=%b ok=%b want 1 1", cnt_err, data_req_ok);
        end
        data_issue = 1'b1;
        tick();
        checks++;
        if (data_req_ok !== 1'b1) begin
            errors++; $display("FAIL data_one_ok: got %b want 1", data_req_ok);
        end
        tick();
        data_issue = 1'b0;
        checks++;
        if (data_req_ok !== 1'b0) begin
            errors++; $display("FAIL data_full: got %b want 0", data_req_ok);
        end
        do_reset();
    endtask

    task automatic test_reset_in_drain();
        inst_issue = 1'b1;
        tick();
        clear_inputs();
        exception_in    = 1'b1;
        exception_pc_in = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        checks++;
        if (stall !== 4'b1111) begin
            errors++; $display("FAIL rst_drain_pre: got stall=%b want 1111", stall);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (stall !== 4'b0000 || {exception, flush_pc_valid, inst_req_ok, data_req_ok} !== 4'b0000
            || flush_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_drain_async: got stall=%b flags=%b pc=%h want 0000 0000 0",
                     stall, {exception, flush_pc_valid, inst_req_ok, data_req_ok}, flush_pc);
        end
        #10 rst = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            checks++;
            if (exception !== 1'b0 || stall !== 4'b0000 || inst_req_ok !== 1'b1) begin
                errors++;
                $display("FAIL rst_drain_after[%0d]: got exc=%b stall=%b ok=%b want 0 0000 1",
                         cyc, exception, stall, inst_req_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall_cascade();
        test_flush_idle();
        test_drain();
        test_second_exception();
        test_counters();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
